// File: rtl/be_pkg.sv
// Shared types and helpers for the back-end load/store unit: instruction
// mnemonics, the LSU state encoding and memory-op classification.
package be_pkg;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK, INVALID
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE
  } lsu_state_t;

  localparam int LSU_TIMEOUT_W = 16;

  function automatic logic is_load(input RV32I_INSTRUCTION_MNEMONIC_t m);
    return (m == LB) || (m == LH) || (m == LW) || (m == LBU) || (m == LHU);
  endfunction

  function automatic logic is_mem_op(input RV32I_INSTRUCTION_MNEMONIC_t m);
    return is_load(m) || (m == SB) || (m == SH) || (m == SW);
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Request/grant/response data-memory bus between the LSU (master) and memory.
interface rv32i_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv32i_lsu_align.sv
// Combinational lane logic: byte enables, store replication and alignment
// check for the issuing op, plus load extract/extend for the op in flight.
module rv32i_lsu_align
  import be_pkg::*;
(
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic [1:0]                  offset,
  input  logic [31:0]                 store_data,
  input  RV32I_INSTRUCTION_MNEMONIC_t rsp_mnemonic,
  input  logic [1:0]                  rsp_offset,
  input  logic [31:0]                 rdata,
  output logic [3:0]                  be,
  output logic [31:0]                 wdata,
  output logic                        misaligned,
  output logic [31:0]                 load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] w;
    w = b;
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] h);
    logic signed [31:0] w;
    w = h;
    return w;
  endfunction

  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    misaligned = 1'b0;
    case (mnemonic)
      LB, LBU, SB: be = 4'b0001 << offset;
      LH, LHU, SH: begin
        be         = 4'b0011 << offset;
        misaligned = offset[0];
      end
      LW, SW: begin
        be         = 4'b1111;
        misaligned = |offset;
      end
      default: ;
    endcase
    case (mnemonic)
      SB:      wdata = {4{store_data[7:0]}};
      SH:      wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase
  end

  // Response side works from the registered op/offset, not the live inputs
  always_comb begin
    lane_b    = rdata[{rsp_offset, 3'b000} +: 8];
    lane_h    = rdata[{rsp_offset[1], 4'b0000} +: 16];
    load_data = 32'h0;
    case (rsp_mnemonic)
      LB:      load_data = sext8(lane_b);
      LBU:     load_data = {24'h0, lane_b};
      LH:      load_data = sext16(lane_h);
      LHU:     load_data = {16'h0, lane_h};
      LW:      load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// Load/store unit: freezes the core while one access runs over the
// request/grant/response bus, then returns the extended result and fault flags.
module rv32i_lsu
  import be_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 store_data,
  output logic                        stall,
  output logic                        done,
  output logic [31:0]                 load_data,
  output logic                        misaligned,
  output logic                        bus_error,
  rv32i_lsu_if.master                 bus
);

  localparam logic [LSU_TIMEOUT_W-1:0] TO_LAST = LSU_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t                  state;
  logic [LSU_TIMEOUT_W-1:0]    cnt;
  RV32I_INSTRUCTION_MNEMONIC_t rsp_mnemonic;
  logic [1:0]                  rsp_offset;
  logic                        mem_op;
  logic [3:0]                  be_c;
  logic [31:0]                 wdata_c;
  logic                        misaligned_c;
  logic [31:0]                 load_c;

  assign mem_op = valid && is_mem_op(mnemonic);
  assign stall  = mem_op && (state != ST_DONE);

  rv32i_lsu_align u_align (
    .mnemonic     (mnemonic),
    .offset       (addr[1:0]),
    .store_data   (store_data),
    .rsp_mnemonic (rsp_mnemonic),
    .rsp_offset   (rsp_offset),
    .rdata        (bus.mem_rdata),
    .be           (be_c),
    .wdata        (wdata_c),
    .misaligned   (misaligned_c),
    .load_data    (load_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rsp_mnemonic  <= LUI;
      rsp_offset    <= 2'b00;
      done          <= 1'b0;
      load_data     <= 32'h0;
      misaligned    <= 1'b0;
      bus_error     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            rsp_mnemonic <= mnemonic;
            rsp_offset   <= addr[1:0];
            if (misaligned_c) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
              load_data  <= 32'h0;
            end else begin
              state         <= ST_REQ;
              cnt           <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= !is_load(mnemonic);
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_be    <= be_c;
              bus.mem_wdata <= wdata_c;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (!is_load(rsp_mnemonic)) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              load_data <= 32'h0;
            end else if (bus.mem_rvalid) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              load_data <= load_c;
            end else begin
              state <= ST_WAIT_RSP;
              cnt   <= '0;
            end
          end else if (cnt == TO_LAST) begin
            bus.mem_req <= 1'b0;
            state       <= ST_DONE;
            done        <= 1'b1;
            bus_error   <= 1'b1;
            load_data   <= 32'h0;
          end else begin
            cnt <= cnt + LSU_TIMEOUT_W'(1);
          end
        end
        ST_WAIT_RSP: begin
          if (bus.mem_rvalid) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            load_data <= load_c;
          end else if (cnt == TO_LAST) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            bus_error <= 1'b1;
            load_data <= 32'h0;
          end else begin
            cnt <= cnt + LSU_TIMEOUT_W'(1);
          end
        end
        ST_DONE: begin
          // Result is only presented for the single DONE cycle
          state      <= ST_IDLE;
          done       <= 1'b0;
          load_data  <= 32'h0;
          misaligned <= 1'b0;
          bus_error  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: directed accesses push expected requests and
// responses; a negedge monitor compares them whenever the DUTs present them.
`timescale 1ns/1ps
module tb_rv32i_lsu;
  import be_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic valid;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  logic [31:0] addr, store_data;
  logic stall, done, misaligned, bus_error;
  logic [31:0] load_data;
  rv32i_lsu_if bus ();

  logic t_valid;
  RV32I_INSTRUCTION_MNEMONIC_t t_mnemonic;
  logic [31:0] t_addr, t_store_data;
  logic t_stall, t_done, t_misaligned, t_bus_error;
  logic [31:0] t_load_data;
  rv32i_lsu_if t_bus ();

  rv32i_lsu dut (
    .clk(clk), .rst(rst), .valid(valid), .mnemonic(mnemonic), .addr(addr),
    .store_data(store_data), .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_error(bus_error), .bus(bus)
  );

  rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .valid(t_valid), .mnemonic(t_mnemonic), .addr(t_addr),
    .store_data(t_store_data), .stall(t_stall), .done(t_done), .load_data(t_load_data),
    .misaligned(t_misaligned), .bus_error(t_bus_error), .bus(t_bus)
  );

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        berr;
    int          cyc;
    string       name;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    string       name;
  } req_t;

  rsp_t q_rsp[$];
  rsp_t q_rsp_to[$];
  req_t q_req[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    req_t r;
    if (!rst) begin
      if (done) begin
        if (q_rsp.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          e = q_rsp.pop_front();
          check({e.name, "_load_data"}, load_data, e.ld);
          check({e.name, "_misaligned"}, 32'(misaligned), 32'(e.mis));
          check({e.name, "_bus_error"}, 32'(bus_error), 32'(e.berr));
          check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.mem_req) begin
        if (q_req.size() == 0) check("unexpected_req", 32'(bus.mem_req), 32'd0);
        else begin
          r = q_req[0];
          check({r.name, "_mem_we"}, 32'(bus.mem_we), 32'(r.we));
          check({r.name, "_mem_addr"}, bus.mem_addr, r.a);
          check({r.name, "_mem_be"}, 32'(bus.mem_be), 32'(r.be));
          check({r.name, "_mem_wdata"}, bus.mem_wdata, r.wd);
          if (bus.mem_gnt) void'(q_req.pop_front());
        end
      end
      if (t_done) begin
        if (q_rsp_to.size() == 0) check("to_unexpected_done", 32'(t_done), 32'd0);
        else begin
          e = q_rsp_to.pop_front();
          check({e.name, "_load_data"}, t_load_data, e.ld);
          check({e.name, "_misaligned"}, 32'(t_misaligned), 32'(e.mis));
          check({e.name, "_bus_error"}, 32'(t_bus_error), 32'(e.berr));
          check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_load_data"}, load_data, 32'h0);
    check({tag, "_misaligned"}, 32'(misaligned), 32'd0);
    check({tag, "_bus_error"}, 32'(bus_error), 32'd0);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    check({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  // Called just after a rising edge; cycle 1 of the access is the current cycle.
  task automatic access(input string name, input RV32I_INSTRUCTION_MNEMONIC_t mn,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_ld, input logic exp_mis,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input int exp_lat);
    rsp_t e;
    req_t r;
    bit   seen;
    bit   ld;
    int   stall_bad;
    int   req_cycles;
    ld     = is_load(mn);
    e.ld   = exp_ld;
    e.mis  = exp_mis;
    e.berr = 1'b0;
    e.cyc  = cyc + exp_lat - 1;
    e.name = name;
    q_rsp.push_back(e);
    if (!exp_mis) begin
      r.we   = !ld;
      r.a    = {a[31:2], 2'b00};
      r.be   = exp_be;
      r.wd   = exp_wd;
      r.name = name;
      q_req.push_back(r);
    end
    valid      = 1'b1;
    mnemonic   = mn;
    addr       = a;
    store_data = sd;
    seen       = 1'b0;
    stall_bad  = 0;
    req_cycles = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      bus.mem_gnt    = !exp_mis && (c == 2 + gnt_dly);
      bus.mem_rvalid = !exp_mis && ld && (c == 2 + gnt_dly + rv_dly);
      bus.mem_rdata  = bus.mem_rvalid ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (bus.mem_req) req_cycles++;
      if (done) begin
        seen = 1'b1;
        if (stall !== 1'b0) stall_bad++;
      end else if (stall !== 1'b1) stall_bad++;
      @(posedge clk);
      #1;
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_stall_profile"}, 32'(stall_bad), 32'd0);
    if (exp_mis) check({name, "_no_mem_req"}, 32'(req_cycles), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t e;
    req_t r;
    int   req_cnt, req_late, done_cnt;

    rst = 1'b1;
    valid = 1'b0; mnemonic = ADD; addr = 32'h0; store_data = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    t_valid = 1'b0; t_mnemonic = ADD; t_addr = 32'h0; t_store_data = 32'h0;
    t_bus.mem_gnt = 1'b0; t_bus.mem_rvalid = 1'b0; t_bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_to_done", 32'(t_done), 32'd0);
    check("reset_to_mem_req", 32'(t_bus.mem_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // name, op, addr, store_data, gnt_dly, rv_dly, rdata, exp_ld, exp_mis, exp_be, exp_wd, latency
    access("sb_1003", SB, 32'h1003, 32'hAABBCCDD, 0, 0, 32'h0, 32'h0, 1'b0, 4'b1000, 32'hDDDDDDDD, 3);
    access("sh_1002", SH, 32'h1002, 32'h1234ABCD, 0, 0, 32'h0, 32'h0, 1'b0, 4'b1100, 32'hABCDABCD, 3);
    access("sw_1004", SW, 32'h1004, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0, 1'b0, 4'b1111, 32'hCAFEF00D, 3);
    access("sb_gnt2", SB, 32'h1000, 32'h000000A5, 2, 0, 32'h0, 32'h0, 1'b0, 4'b0001, 32'hA5A5A5A5, 5);
    access("lb_8000", LB, 32'h2001, 32'h0, 0, 1, 32'h00008000, 32'hFFFFFF80, 1'b0, 4'b0010, 32'h0, 4);
    access("lbu_f000", LBU, 32'h2001, 32'h0, 0, 1, 32'h0000F000, 32'h000000F0, 1'b0, 4'b0010, 32'h0, 4);
    access("lb_f000", LB, 32'h2001, 32'h0, 0, 1, 32'h0000F000, 32'hFFFFFFF0, 1'b0, 4'b0010, 32'h0, 4);
    access("lbu_8000", LBU, 32'h2001, 32'h0, 0, 1, 32'h00008000, 32'h00000080, 1'b0, 4'b0010, 32'h0, 4);
    access("lb_2003", LB, 32'h2003, 32'h0, 0, 1, 32'h7F000000, 32'h0000007F, 1'b0, 4'b1000, 32'h0, 4);
    access("lw_mis", LW, 32'h2002, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 2);
    access("lh_slow", LH, 32'h3002, 32'h0, 5, 2, 32'h80010000, 32'hFFFF8001, 1'b0, 4'b1100, 32'h0, 10);
    access("lh_3000", LH, 32'h3000, 32'h0, 0, 1, 32'hABCD8765, 32'hFFFF8765, 1'b0, 4'b0011, 32'h0, 4);
    access("lhu_3000", LHU, 32'h3000, 32'h0, 0, 1, 32'h1234F00D, 32'h0000F00D, 1'b0, 4'b0011, 32'h0, 4);
    access("lw_same", LW, 32'h3008, 32'h0, 0, 0, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 4'b1111, 32'h0, 3);
    access("lh_mis", LH, 32'h3001, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 2);
    access("sh_mis", SH, 32'h1001, 32'h5555AAAA, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 2);
    access("sw_mis", SW, 32'h1002, 32'h5555AAAA, 0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 2);

    // Non-memory instruction: no stall, no bus activity, no completion
    valid = 1'b1; mnemonic = ADD; addr = 32'h1000;
    req_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (stall !== 1'b0) req_cnt++;
      @(posedge clk);
      #1;
    end
    check("add_no_stall", 32'(req_cnt), 32'd0);

    // Reset while a load waits for its response
    r.we = 1'b0; r.a = 32'h5000; r.be = 4'b1111; r.wd = 32'h11112222; r.name = "lw_rst";
    q_req.push_back(r);
    valid = 1'b1; mnemonic = LW; addr = 32'h5000; store_data = 32'h11112222;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    valid = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check_idle("after_rst");
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.mem_rvalid = 1'b0;
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;

    // Timeout instance: grant never arrives, stray responses afterwards
    e.ld = 32'h0; e.mis = 1'b0; e.berr = 1'b1; e.cyc = cyc + 5; e.name = "lw_timeout";
    q_rsp_to.push_back(e);
    t_valid = 1'b1; t_mnemonic = LW; t_addr = 32'h4000;
    req_cnt = 0; req_late = 0; done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      t_bus.mem_rvalid = (c >= 5);
      t_bus.mem_rdata  = 32'h12345678;
      @(negedge clk);
      if (t_bus.mem_req) req_cnt++;
      if (c >= 6 && t_bus.mem_req) req_late++;
      if (t_done) done_cnt++;
      if (c == 2) begin
        check("to_mem_addr", t_bus.mem_addr, 32'h4000);
        check("to_mem_be", 32'(t_bus.mem_be), 32'hF);
        check("to_mem_we", 32'(t_bus.mem_we), 32'd0);
      end
      @(posedge clk); #1;
      if (c == 6) t_valid = 1'b0;
    end
    t_bus.mem_rvalid = 1'b0;
    check("to_req_cycles", 32'(req_cnt), 32'd4);
    check("to_req_after", 32'(req_late), 32'd0);
    check("to_done_count", 32'(done_cnt), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("rsp_queue_empty", 32'(q_rsp.size()), 32'd0);
    check("req_queue_empty", 32'(q_req.size()), 32'd0);
    check("to_queue_empty", 32'(q_rsp_to.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
